gpio_serial_loader: RTL



---
 rtl/gpio_loader_pkg.sv | 25 ++
 rtl/gpio_loader_tick.sv | 48 ++++
 rtl/gpio_serial_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_loader_pkg.sv
// Shared definitions for the GPIO serial configuration loader.
//   loader_state_t : sequencer state encoding
//   GPIO_NUM_IO    : default number of pads in the mprj_io chain
//   GPIO_CFG_BITS  : default configuration word width per pad
//   clog2_min1()   : $clog2 that never returns 0, for counter widths
package gpio_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LOAD     = 3'd4,
    ST_DONE     = 3'd5
  } loader_state_t;

  localparam int GPIO_NUM_IO   = 38;
  localparam int GPIO_CFG_BITS = 13;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_loader_tick.sv
// Half-period timer for the serial loader.
// Counts DIV system-clock cycles and raises `tick` on the last one, so a
// state that waits for `tick` lasts exactly DIV cycles. `clear` is asserted
// by the sequencer on every state change so each state starts counting at 0.
//   clock : system clock
//   reset : asynchronous, active-high reset
//   clear : restart the count on the next edge
//   tick  : high during the DIV-th cycle of the current count
module gpio_loader_tick
  import gpio_loader_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: restart on state change or on wrap, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Sequencer that copies per-pad GPIO configuration words from the
// housekeeping register file into the mprj_io control-block shift chain.
// The highest pad is fetched and shifted first (MSB first), then a
// serial_load strobe makes every pad latch its new mode together.
//   clock        : system clock
//   reset        : asynchronous, active-high reset
//   start        : request a full chain load (honoured only when idle)
//   busy         : transfer in progress (FETCH .. LOAD)
//   done         : one-cycle completion pulse
//   cfg_addr     : pad index presented to the register file
//   cfg_data     : combinational word for cfg_addr
//   serial_clock : chain shift clock
//   serial_data  : chain data
//   serial_load  : chain latch strobe
// All outputs come straight from flops; their next values are derived from
// the next state so they line up with the state they describe.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int NUM_IO   = GPIO_NUM_IO,
  parameter int CFG_BITS = GPIO_CFG_BITS,
  parameter int DIV      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_IO)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]       cfg_data,
  output logic                      serial_clock,
  output logic                      serial_data,
  output logic                      serial_load
);

  localparam int            AW       = $clog2(NUM_IO);
  localparam int            BW       = clog2_min1(CFG_BITS);
  localparam logic [AW-1:0] PAD_TOP  = AW'(NUM_IO - 1);
  localparam logic [AW-1:0] PAD_ONE  = AW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  loader_state_t       state_q, state_d;
  logic [AW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic [AW-1:0]       cfg_addr_q, cfg_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                sload_q, sload_d;
  logic                tick_s;
  logic                state_change_s;

  assign state_change_s = (state_d != state_q);

  gpio_loader_tick #(
    .DIV (DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state_change_s),
    .tick  (tick_s)
  );

  // Sequencer next state, counters, shift register and output values.
  always_comb begin
    state_d    = state_q;
    pad_d      = pad_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    cfg_addr_d = cfg_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pad_d   = PAD_TOP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        shreg_d = cfg_data;
        bit_d   = '0;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (tick_s) begin
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (tick_s) begin
          shreg_d = {shreg_q[CFG_BITS-2:0], 1'b0};
          bit_d   = bit_q + BIT_ONE;
          // Decision uses the pre-increment bit index.
          if (bit_q < BIT_LAST) begin
            state_d = ST_SHIFT_LO;
          end else if (pad_q != '0) begin
            pad_d   = pad_q - PAD_ONE;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_LOAD: begin
        if (tick_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // cfg_addr changes only when a FETCH begins, so the register file
    // output is settled for the whole FETCH cycle.
    if (state_d == ST_FETCH) begin
      cfg_addr_d = pad_d;
    end else begin
      cfg_addr_d = cfg_addr_q;
    end

    busy_d  = (state_d == ST_FETCH) || (state_d == ST_SHIFT_LO) ||
              (state_d == ST_SHIFT_HI) || (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
    sclk_d  = (state_d == ST_SHIFT_HI);
    sload_d = (state_d == ST_LOAD);
    // Data follows the MSB of the next shift-register value so it is set up
    // as SHIFT_LO begins and held unchanged through SHIFT_HI.
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
      sdata_d = shreg_d[CFG_BITS-1];
    end else begin
      sdata_d = 1'b0;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pad_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      cfg_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sload_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pad_q      <= pad_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      cfg_addr_q <= cfg_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      sload_q    <= sload_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_addr     = cfg_addr_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;

endmodule
